// File: rtl/inst_fetch_stepper.sv
// inst_fetch_stepper: debounced or free-running instruction fetch stepper.
// Drives a synchronous ROM and shows a selectable LED slice of the fetched word.
module inst_fetch_stepper #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 6,
   parameter int LED_W   = 8,
   parameter int SEL_W   = 2,
   parameter int DEB_LEN = 8,
   parameter int MEM_LAT = 1,
   parameter int RUN_DIV = 50
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Button,
   input  logic              Mode,
   input  logic [SEL_W-1:0]  Select,
   input  logic [DATA_W-1:0] Mem_data,
   output logic [ADDR_W-1:0] Mem_addr,
   output logic              Mem_rd,
   output logic [ADDR_W+1:0] PC,
   output logic [DATA_W-1:0] Inst,
   output logic              Valid,
   output logic              Wrap,
   output logic [LED_W-1:0]  LED
);

   localparam int SLICES = DATA_W / LED_W;
   localparam int RUN_W  = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
   localparam int LAT_W  = $clog2(MEM_LAT + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_DIV - 1);
   localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MEM_LAT);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [1:0]         r_sync;
   logic [DEB_LEN-1:0] r_shift;
   logic               r_deb;
   logic               r_deb_q;
   logic [RUN_W-1:0]   r_run;
   logic [1:0]         r_state;
   logic [LAT_W-1:0]   r_lat;
   logic               r_rd;
   logic               r_valid;
   logic               r_wrap;
   logic [ADDR_W+1:0]  r_pc;
   logic [DATA_W-1:0]  r_inst;
   logic [LED_W-1:0]   r_led;

   logic               w_press;
   logic               w_tick;
   logic               w_trig;
   logic [LED_W-1:0]   w_led;

   // Level only moves once the whole window agrees, so bounce never toggles it
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_sync  <= '0;
         r_shift <= '0;
         r_deb   <= 1'b0;
         r_deb_q <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], Button};
         r_shift <= {r_shift[DEB_LEN-2:0], r_sync[1]};
         r_deb_q <= r_deb;
         if (&r_shift)
            r_deb <= 1'b1;
         else if (~|r_shift)
            r_deb <= 1'b0;
      end
   end

   assign w_press = r_deb & ~r_deb_q;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)
         r_run <= '0;
      else if (!Mode || r_run == RUN_MAX)
         r_run <= '0;
      else
         r_run <= r_run + 1'b1;
   end

   assign w_tick = Mode & (r_run == RUN_MAX);
   assign w_trig = Mode ? w_tick : w_press;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state <= S_IDLE;
         r_lat   <= '0;
         r_rd    <= 1'b0;
         r_valid <= 1'b0;
         r_wrap  <= 1'b0;
         r_pc    <= '0;
         r_inst  <= '0;
      end else begin
         r_rd    <= 1'b0;
         r_valid <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_trig) begin
                  r_rd    <= 1'b1;
                  r_state <= S_FETCH;
               end
            end
            S_FETCH: begin
               r_lat   <= LAT_W'(1);
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_lat == LAT_MAX) begin
                  r_inst  <= Mem_data;
                  r_valid <= 1'b1;
                  r_pc    <= r_pc + (ADDR_W+2)'(4);
                  if (&r_pc[ADDR_W+1:2])
                     r_wrap <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_lat <= r_lat + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Out-of-range select blanks the LEDs
   always_comb begin
      w_led = '0;
      for (int i = 0; i < SLICES; i++)
         if (Select == SEL_W'(i))
            w_led = r_inst[i*LED_W +: LED_W];
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)
         r_led <= '0;
      else
         r_led <= w_led;
   end

   assign Mem_addr = r_pc[ADDR_W+1:2];
   assign Mem_rd   = r_rd;
   assign PC       = r_pc;
   assign Inst     = r_inst;
   assign Valid    = r_valid;
   assign Wrap     = r_wrap;
   assign LED      = r_led;

endmodule
